// File: rtl/asu_riscv_divider_if.sv
// ============================================================================
// Module   : asu_riscv_divider_if
// Brief    : Request/response bundle between a divider client and asu_riscv_divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface asu_riscv_divider_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] op_a_i;
    logic [WIDTH-1:0] op_b_i;
    logic             flush_i;
    logic             busy_o;
    logic             valid_o;
    logic [WIDTH-1:0] result_o;

    modport master (
        output start_i, op_i, op_a_i, op_b_i, flush_i,
        input  busy_o, valid_o, result_o
    );

    modport slave (
        input  start_i, op_i, op_a_i, op_b_i, flush_i,
        output busy_o, valid_o, result_o
    );
endinterface

`default_nettype wire

// File: rtl/asu_riscv_divider.sv
// ============================================================================
// Module   : asu_riscv_divider
// Brief    : Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one bit per clock.
// Revision : 1.0
// ============================================================================
`default_nettype none

module asu_riscv_divider #(
    parameter int WIDTH     = 32,
    parameter bit FAST_SPEC = 1'b1
) (
    input  wire logic           clk,
    input  wire logic           nrst,
    asu_riscv_divider_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_count;
    logic             r_is_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_result;
    logic             r_valid;

    logic             w_signed;
    logic             w_sa;
    logic             w_sb;
    logic             w_bzero;
    logic             w_ovf;
    logic             w_special;
    logic             w_start;
    logic             w_emit;
    logic             w_last;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    assign w_signed  = ~bus.op_i[0];
    assign w_sa      = w_signed & bus.op_a_i[WIDTH-1];
    assign w_sb      = w_signed & bus.op_b_i[WIDTH-1];
    assign w_abs_a   = w_sa ? -bus.op_a_i : bus.op_a_i;
    assign w_abs_b   = w_sb ? -bus.op_b_i : bus.op_b_i;
    assign w_bzero   = (bus.op_b_i == '0);
    assign w_ovf     = w_signed & (bus.op_a_i == {1'b1, {(WIDTH-1){1'b0}}}) & (&bus.op_b_i);
    assign w_special = FAST_SPEC & (w_bzero | w_ovf);

    // Partial remainder is always below the divisor, so WIDTH+1 bits hold the trial exactly.
    assign w_trial   = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_div};
    assign w_last    = (r_count == CW'(WIDTH-1));
    assign w_q_fix   = r_neg_q ? -r_quo : r_quo;
    assign w_r_fix   = r_neg_r ? -r_rem : r_rem;

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_emit  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start_i) begin
                    w_start = 1'b1;
                    w_next  = w_special ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (bus.flush_i)  w_next = S_IDLE;
                else if (w_last)  w_next = S_FIX;
            end
            S_FIX: begin
                w_next = S_IDLE;
                w_emit = ~bus.flush_i;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_count  <= '0;
            r_is_rem <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_valid <= w_emit;
            if (w_start) begin
                r_is_rem <= bus.op_i[1];
                r_count  <= '0;
                r_div    <= w_abs_b;
                if (w_special) begin
                    // Preset so FIX passes the RISC-V defined values through untouched.
                    r_neg_q <= 1'b0;
                    r_neg_r <= 1'b0;
                    r_quo   <= w_bzero ? {WIDTH{1'b1}} : bus.op_a_i;
                    r_rem   <= w_bzero ? bus.op_a_i : '0;
                end else begin
                    r_neg_q <= (w_sa ^ w_sb) & ~w_bzero;
                    r_neg_r <= w_sa;
                    r_quo   <= w_abs_a;
                    r_rem   <= '0;
                end
            end else if (r_state == S_CALC) begin
                r_count <= r_count + 1'b1;
                if (!w_trial[WIDTH]) begin
                    r_rem <= w_trial[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                end else begin
                    r_rem <= {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
                    r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                end
            end
            if (w_emit) r_result <= r_is_rem ? w_r_fix : w_q_fix;
        end
    end

    assign bus.busy_o   = (r_state != S_IDLE);
    assign bus.valid_o  = r_valid;
    assign bus.result_o = r_result;
endmodule

`default_nettype wire
